// File: rtl/card_display_monitor_if.sv
// Bundle of baccarat display taps (HEX/LEDR in) and decoded/check results out.
interface card_display_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 sample_en;
    logic [6:0]           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]           LEDR;
    logic [3:0]           pcard1, pcard2, pcard3;
    logic [3:0]           dcard1, dcard2, dcard3;
    logic [3:0]           pscore_calc, dscore_calc;
    logic [2:0]           card_count;
    logic                 check_valid;
    logic                 hex_err, score_err, order_err, win_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output sample_en, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
               pscore_calc, dscore_calc, card_count, check_valid,
               hex_err, score_err, order_err, win_err, err_count
    );

    modport slave (
        input  sample_en, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
               pscore_calc, dscore_calc, card_count, check_valid,
               hex_err, score_err, order_err, win_err, err_count
    );
endinterface

// File: rtl/card_display_monitor.sv
// Passive baccarat display checker: decodes HEX5..HEX0, rescores both hands, checks LEDR.
// Define WINNER_CHECK_EN to also check the win lights against the recomputed scores.
module card_display_monitor #(
    parameter int ERR_CNT_W   = 8,
    parameter bit STRICT_STEP = 1'b1
) (
    input logic                   fast_clock,
    input logic                   reset,
    card_display_monitor_if.slave mon
);
    localparam int NUM_LANES = 6;
    localparam int STAGES    = 1;

    typedef enum logic [2:0] {IDLE, P1, D1, P2, D2, P3, D3} state_t;

    function automatic logic [3:0] decode(input logic [6:0] h);
        case (h)
            7'b1111111: decode = 4'd0;
            7'b0001000: decode = 4'd1;
            7'b0100100: decode = 4'd2;
            7'b0110000: decode = 4'd3;
            7'b0011001: decode = 4'd4;
            7'b0010010: decode = 4'd5;
            7'b0000010: decode = 4'd6;
            7'b1111000: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0010000: decode = 4'd9;
            7'b1000000: decode = 4'd10;
            7'b1100001: decode = 4'd11;
            7'b0011000: decode = 4'd12;
            7'b0001001: decode = 4'd13;
            default:    decode = 4'd15;
        endcase
    endfunction

    function automatic logic [4:0] pts(input logic [3:0] r);
        pts = (r >= 4'd1 && r <= 4'd9) ? {1'b0, r} : 5'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] t;
        if (s >= 5'd20)      t = s - 5'd20;
        else if (s >= 5'd10) t = s - 5'd10;
        else                 t = s;
        mod10 = t[3:0];
    endfunction

    // S0: raw capture, lanes stored in deal order (PC1,DC1,PC2,DC2,PC3,DC3)
    logic [STAGES:0]                 vld_pipe;
    logic [NUM_LANES-1:0][6:0]       hex_q;
`ifdef WINNER_CHECK_EN
    logic [9:0]                      ledr_q;
`else
    logic [7:0]                      ledr_q;
`endif

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            hex_q    <= '0;
            ledr_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], mon.sample_en};
            if (mon.sample_en) begin
                hex_q  <= {mon.HEX5, mon.HEX2, mon.HEX4, mon.HEX1, mon.HEX3, mon.HEX0};
                ledr_q <= mon.LEDR[$bits(ledr_q)-1:0];
            end
        end
    end

    // S1: per-lane decode and hand scores
    logic [NUM_LANES-1:0][3:0] rank;
    logic [NUM_LANES-1:0]      present;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign rank[g]    = decode(hex_q[g]);
        assign present[g] = (rank[g] != 4'd0);
    end

    logic [3:0] pscore, dscore;
    assign pscore = mod10(pts(rank[0]) + pts(rank[2]) + pts(rank[4]));
    assign dscore = mod10(pts(rank[1]) + pts(rank[3]) + pts(rank[5]));

    // S2: checks against order FSM and held ranks
    state_t                    state;
    logic [NUM_LANES-1:0][3:0] held;
    logic [2:0]                n_present;
    logic                      hex_bad, unstable, is_prefix, shrink, step_bad;
    logic                      order_bad, score_bad, win_bad, any_bad;

    always_comb begin
        n_present = '0;
        hex_bad   = 1'b0;
        unstable  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_present = n_present + 3'(present[i]);
            if (rank[i] == 4'd15) hex_bad = 1'b1;
            if (i < int'(state) && rank[i] != held[i]) unstable = 1'b1;
        end
    end

    // a legal hand fills the low lanes contiguously: x & (x+1) clears the run of ones
    assign is_prefix = ((present & (present + 6'd1)) == 6'd0);
    assign shrink    = (n_present < 3'(state));
    assign step_bad  = STRICT_STEP && ({1'b0, n_present} > ({1'b0, 3'(state)} + 4'd1));
    assign order_bad = (n_present != 3'd0) && (!is_prefix || shrink || step_bad || unstable);
    assign score_bad = (ledr_q[7:0] != {dscore, pscore});

`ifdef WINNER_CHECK_EN
    logic [1:0] win_exp;
    assign win_exp = (pscore > dscore) ? 2'b01 : (dscore > pscore) ? 2'b10 : 2'b11;
    assign win_bad = (ledr_q[9:8] != 2'b00) && (ledr_q[9:8] != win_exp);
`else
    assign win_bad = 1'b0;
`endif

    assign any_bad = hex_bad | score_bad | order_bad | win_bad;

    logic [NUM_LANES-1:0][3:0] cards_q;
    logic [3:0]                pscore_q, dscore_q;
    logic [2:0]                count_q;
    logic                      hex_err_q, score_err_q, order_err_q, win_err_q;
    logic [ERR_CNT_W-1:0]      err_cnt;

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held        <= '0;
            cards_q     <= '0;
            pscore_q    <= '0;
            dscore_q    <= '0;
            count_q     <= '0;
            hex_err_q   <= 1'b0;
            score_err_q <= 1'b0;
            order_err_q <= 1'b0;
            win_err_q   <= 1'b0;
            err_cnt     <= '0;
        end else if (vld_pipe[0]) begin
            cards_q     <= rank;
            pscore_q    <= pscore;
            dscore_q    <= dscore;
            count_q     <= n_present;
            hex_err_q   <= hex_bad;
            score_err_q <= score_bad;
            order_err_q <= order_bad;
            win_err_q   <= win_bad;
            if (any_bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            // on an order violation the FSM and held ranks stay put
            if (n_present == 3'd0) begin
                state <= IDLE;
                held  <= '0;
            end else if (!order_bad) begin
                state <= state_t'(n_present);
                held  <= rank;
            end
        end
    end

    assign mon.pcard1      = cards_q[0];
    assign mon.dcard1      = cards_q[1];
    assign mon.pcard2      = cards_q[2];
    assign mon.dcard2      = cards_q[3];
    assign mon.pcard3      = cards_q[4];
    assign mon.dcard3      = cards_q[5];
    assign mon.pscore_calc = pscore_q;
    assign mon.dscore_calc = dscore_q;
    assign mon.card_count  = count_q;
    assign mon.check_valid = vld_pipe[STAGES];
    assign mon.hex_err     = hex_err_q;
    assign mon.score_err   = score_err_q;
    assign mon.order_err   = order_err_q;
    assign mon.win_err     = win_err_q;
    assign mon.err_count   = err_cnt;
endmodule

// File: tb/tb_card_display_monitor.sv
// Scoreboard bench for card_display_monitor: directed hands, expected results queued at issue.
module tb_card_display_monitor;
    logic fast_clock = 1'b0;
    logic reset;
    always #5 fast_clock = ~fast_clock;

    card_display_monitor_if #(.ERR_CNT_W(8)) bus ();

    card_display_monitor #(.ERR_CNT_W(8), .STRICT_STEP(1'b1)) dut (
        .fast_clock (fast_clock),
        .reset      (reset),
        .mon        (bus)
    );

`ifdef WINNER_CHECK_EN
    localparam logic [7:0] W = 8'd1;
`else
    localparam logic [7:0] W = 8'd0;
`endif

    localparam logic [6:0] BL = 7'b1111111, CA = 7'b0001000, C2 = 7'b0100100;
    localparam logic [6:0] C8 = 7'b0000000, CJ = 7'b1100001, BAD = 7'b0101010;

    typedef struct {
        logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, ps, ds;
        logic [2:0] cnt;
        logic       he, se, oe, we;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cv_seen = 0;

    function automatic exp_t mk(input logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, ps, ds,
                                input logic [2:0] cnt, input logic he, se, oe, we,
                                input logic [7:0] ec);
        exp_t e;
        e.pc1 = pc1; e.pc2 = pc2; e.pc3 = pc3;
        e.dc1 = dc1; e.dc2 = dc2; e.dc3 = dc3;
        e.ps = ps; e.ds = ds; e.cnt = cnt;
        e.he = he; e.se = se; e.oe = oe; e.we = we; e.ec = ec;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // issue one sample this cycle; returns 1 time unit after the capturing edge
    task automatic send(input logic [6:0] h0, h1, h2, h3, h4, h5, input logic [9:0] ledr,
                        input exp_t e, input bit push);
        bus.HEX0 = h0; bus.HEX1 = h1; bus.HEX2 = h2;
        bus.HEX3 = h3; bus.HEX4 = h4; bus.HEX5 = h5;
        bus.LEDR = ledr;
        bus.sample_en = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge fast_clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " check_valid"}, bus.check_valid, 0);
        chk({tag, " pcard1"}, bus.pcard1, 0);
        chk({tag, " dcard3"}, bus.dcard3, 0);
        chk({tag, " pscore"}, bus.pscore_calc, 0);
        chk({tag, " dscore"}, bus.dscore_calc, 0);
        chk({tag, " card_count"}, bus.card_count, 0);
        chk({tag, " flags"}, {bus.hex_err, bus.score_err, bus.order_err, bus.win_err}, 0);
        chk({tag, " err_count"}, bus.err_count, 0);
    endtask

    always @(negedge fast_clock) begin
        if (!reset && bus.check_valid) begin
            cv_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected check_valid: got 1, expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pcard1", bus.pcard1, e.pc1);
                chk("pcard2", bus.pcard2, e.pc2);
                chk("pcard3", bus.pcard3, e.pc3);
                chk("dcard1", bus.dcard1, e.dc1);
                chk("dcard2", bus.dcard2, e.dc2);
                chk("dcard3", bus.dcard3, e.dc3);
                chk("pscore_calc", bus.pscore_calc, e.ps);
                chk("dscore_calc", bus.dscore_calc, e.ds);
                chk("card_count", bus.card_count, e.cnt);
                chk("hex_err", bus.hex_err, e.he);
                chk("score_err", bus.score_err, e.se);
                chk("order_err", bus.order_err, e.oe);
                chk("win_err", bus.win_err, e.we);
                chk("err_count", bus.err_count, e.ec);
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge fast_clock);
        chk({tag, " pending expectations"}, exp_q.size(), 0);
    endtask

    initial begin
        int seen0;
        reset = 1'b1;
        bus.sample_en = 1'b0;
        {bus.HEX0, bus.HEX1, bus.HEX2} = {BL, BL, BL};
        {bus.HEX3, bus.HEX4, bus.HEX5} = {BL, BL, BL};
        bus.LEDR = '0;
        repeat (2) @(posedge fast_clock);
        @(negedge fast_clock);
        chk_zero("reset");
        @(posedge fast_clock); #1;
        reset = 1'b0;

        // back-to-back hands; HEX order h0..h5, player = h0..h2, dealer = h3..h5
        send(BL, BL, BL, BL, BL, BL, 10'h000, mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0, 0), 1);
        send(CA, BL, BL, BL, BL, BL, 10'h001, mk(1,0,0, 0,0,0, 1,0, 1, 0,0,0,0, 0), 1);
        send(CA, BL, BL, CA, BL, BL, 10'h011, mk(1,0,0, 1,0,0, 1,1, 2, 0,0,0,0, 0), 1);
        send(CA, C8, BL, CA, BL, BL, 10'h019, mk(1,8,0, 1,0,0, 9,1, 3, 0,0,0,0, 0), 1);
        send(CA, C8, BL, CA, CJ, BL, 10'h119, mk(1,8,0, 1,11,0, 9,1, 4, 0,0,0,0, 0), 1);
        send(CA, C8, BL, CA, CJ, BL, 10'h219, mk(1,8,0, 1,11,0, 9,1, 4, 0,0,0,W[0], W), 1);
        send(BL, BL, BL, BL, BL, BL, 10'h000, mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0, W), 1);
        send(CA, C8, BL, BL, BL, BL, 10'h009, mk(1,8,0, 0,0,0, 9,0, 2, 0,0,1,0, 8'd1+W), 1);
        send(BL, BL, BL, BL, BL, BL, 10'h000, mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0, 8'd1+W), 1);
        send(BL, BL, BAD, BL, BL, BL, 10'h005, mk(0,0,15, 0,0,0, 0,0, 1, 1,1,1,0, 8'd2+W), 1);
        send(BL, BL, BL, BL, BL, BL, 10'h000, mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0, 8'd2+W), 1);
        send(CA, BL, BL, C2, BL, BL, 10'h021, mk(1,0,0, 2,0,0, 1,2, 2, 0,0,1,0, 8'd3+W), 1);
        send(CA, BL, BL, BL, BL, BL, 10'h001, mk(1,0,0, 0,0,0, 1,0, 1, 0,0,0,0, 8'd3+W), 1);
        send(C2, BL, BL, BL, BL, BL, 10'h002, mk(2,0,0, 0,0,0, 2,0, 1, 0,0,1,0, 8'd4+W), 1);
        send(BL, BL, BL, BL, BL, BL, 10'h000, mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0, 8'd4+W), 1);
        bus.sample_en = 1'b0;
        drain("hands");

        reset = 1'b1;
        @(negedge fast_clock);
        chk_zero("second reset");
        @(posedge fast_clock); #1;
        reset = 1'b0;

        // three back-to-back samples, reset lands while the later two are in flight
        seen0 = cv_seen;
        send(CA, BL, BL, BL, BL, BL, 10'h001, mk(1,0,0, 0,0,0, 1,0, 1, 0,0,0,0, 0), 1);
        send(CA, BL, BL, CA, BL, BL, 10'h011, mk(1,0,0, 1,0,0, 1,1, 2, 0,0,0,0, 0), 0);
        send(CA, C8, BL, CA, BL, BL, 10'h019, mk(1,8,0, 1,0,0, 9,1, 3, 0,0,0,0, 0), 0);
        bus.sample_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge fast_clock);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge fast_clock);
        chk("check_valid count across reset", cv_seen - seen0, 1);
        drain("reset flush");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
